// File: rtl/mastermind_pkg.sv
// Shared sizing, types and state encoding for the Mastermind secret-code generator.
package mastermind_pkg;

  localparam int NUM_PEGS   = 4;
  localparam int NUM_COLORS = 6;
  localparam int COLOR_W    = 3;

  typedef logic [COLOR_W-1:0] color_t;
  typedef color_t code_t [NUM_PEGS];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } gen_state_t;

endpackage

// File: rtl/mastermind_color_check.sv
// Combinational legality check for one candidate colour, plus the fallback colour
// used when the reject budget for the current peg is exhausted.
module mastermind_color_check
  import mastermind_pkg::*;
#(
  parameter int NUM_PEGS   = mastermind_pkg::NUM_PEGS,
  parameter int NUM_COLORS = mastermind_pkg::NUM_COLORS,
  parameter int COLOR_W    = mastermind_pkg::COLOR_W,
  parameter int IDX_W      = 2
) (
  input  logic [COLOR_W-1:0]          cand,
  input  logic [NUM_PEGS*COLOR_W-1:0] pegs,
  input  logic [IDX_W-1:0]            peg_idx,
  input  logic                        repeat_ok,
  output logic                        accept,
  output logic [COLOR_W-1:0]          fallback
);

  logic [NUM_PEGS-1:0]   filled;
  logic [NUM_PEGS-1:0]   dup_hit;
  logic [NUM_COLORS-1:0] used;
  logic                  in_range;

  // Only pegs below peg_idx have been written for the current code.
  generate
    for (genvar gi = 0; gi < NUM_PEGS; gi++) begin : g_peg
      assign filled[gi]  = (gi < int'(peg_idx));
      assign dup_hit[gi] = filled[gi] && (pegs[gi*COLOR_W +: COLOR_W] == cand);
    end

    for (genvar gi = 0; gi < NUM_COLORS; gi++) begin : g_color
      logic [NUM_PEGS-1:0] hit;
      for (genvar gj = 0; gj < NUM_PEGS; gj++) begin : g_hit
        assign hit[gj] = filled[gj] && (pegs[gj*COLOR_W +: COLOR_W] == COLOR_W'(gi));
      end
      assign used[gi] = |hit;
    end
  endgenerate

  assign in_range = ({1'b0, cand} < (COLOR_W+1)'(NUM_COLORS));
  assign accept   = in_range && (repeat_ok || !(|dup_hit));

  // Descending scan so the lowest unused colour wins; one always exists since NUM_COLORS >= NUM_PEGS.
  always_comb begin
    fallback = '0;
    for (int c = NUM_COLORS - 1; c >= 0; c--) begin
      if (!used[c]) fallback = COLOR_W'(c);
    end
    if (repeat_ok) fallback = '0;
  end

endmodule

// File: rtl/mastermind_code_gen.sv
// Rejection-sampling controller: collects NUM_PEGS legal colours from the LFSR word
// and presents them as one packed secret code with a done pulse.
module mastermind_code_gen
  import mastermind_pkg::*;
#(
  parameter int NUM_PEGS   = mastermind_pkg::NUM_PEGS,
  parameter int NUM_COLORS = mastermind_pkg::NUM_COLORS,
  parameter int COLOR_W    = mastermind_pkg::COLOR_W,
  parameter int RAND_W     = 10,
  parameter int MAX_REJECT = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        allow_repeat,
  input  logic [RAND_W-1:0]           rand_in,
  output logic [NUM_PEGS*COLOR_W-1:0] code_out,
  output logic                        code_valid,
  output logic                        busy,
  output logic                        done
);

  localparam int IDX_W = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;
  localparam int REJ_W = (MAX_REJECT > 1) ? $clog2(MAX_REJECT) : 1;

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_COLLECT = COLLECT;
  localparam logic [1:0] S_DONE    = DONE;

  logic [1:0]                  state_reg;
  logic [IDX_W-1:0]            peg_idx_reg;
  logic [REJ_W-1:0]            reject_cnt_reg;
  logic                        repeat_reg;
  logic [NUM_PEGS*COLOR_W-1:0] code_reg;
  logic                        code_valid_reg;
  logic                        busy_reg;
  logic                        done_reg;

  logic [COLOR_W-1:0] cand;
  logic               cand_accept;
  logic [COLOR_W-1:0] fallback;
  logic               forced;
  logic               take;
  logic [COLOR_W-1:0] take_color;
  logic               unused_rand_bits;

  assign cand             = rand_in[COLOR_W-1:0];
  assign unused_rand_bits = ^rand_in[RAND_W-1:COLOR_W];

  mastermind_color_check #(
    .NUM_PEGS   (NUM_PEGS),
    .NUM_COLORS (NUM_COLORS),
    .COLOR_W    (COLOR_W),
    .IDX_W      (IDX_W)
  ) u_color_check (
    .cand      (cand),
    .pegs      (code_reg),
    .peg_idx   (peg_idx_reg),
    .repeat_ok (repeat_reg),
    .accept    (cand_accept),
    .fallback  (fallback)
  );

  assign forced     = (reject_cnt_reg == REJ_W'(MAX_REJECT - 1));
  assign take       = cand_accept || forced;
  assign take_color = cand_accept ? cand : fallback;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      peg_idx_reg    <= '0;
      reject_cnt_reg <= '0;
      repeat_reg     <= 1'b0;
      code_reg       <= '0;
      code_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
          if (start) begin
            state_reg      <= S_COLLECT;
            repeat_reg     <= allow_repeat;
            code_reg       <= '0;
            code_valid_reg <= 1'b0;
            peg_idx_reg    <= '0;
            reject_cnt_reg <= '0;
            busy_reg       <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (take) begin
            code_reg[peg_idx_reg*COLOR_W +: COLOR_W] <= take_color;
            reject_cnt_reg <= '0;
            if (peg_idx_reg == IDX_W'(NUM_PEGS - 1)) begin
              state_reg      <= S_DONE;
              peg_idx_reg    <= '0;
              done_reg       <= 1'b1;
              code_valid_reg <= 1'b1;
              busy_reg       <= 1'b0;
            end else begin
              peg_idx_reg <= peg_idx_reg + 1'b1;
            end
          end else begin
            reject_cnt_reg <= reject_cnt_reg + 1'b1;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign code_out   = code_reg;
  assign code_valid = code_valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_mastermind_code_gen.sv
// Directed-vector bench for mastermind_code_gen with hand-computed codes and latencies.
module tb_mastermind_code_gen;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        allow_repeat;
  logic [9:0]  rand_in;
  logic [11:0] code_out;
  logic        code_valid;
  logic        busy;
  logic        done;

  int total_checks = 0;
  int pass_checks  = 0;

  logic [9:0] stim [8];

  mastermind_code_gen dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .allow_repeat (allow_repeat),
    .rand_in      (rand_in),
    .code_out     (code_out),
    .code_valid   (code_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_checks++;
    if (got === exp) begin
      pass_checks++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulses start, feeds stim[0..n-1] then 10'h3FF, and checks latency (start edge T -> done in T+exp_lat).
  task automatic run_code(input string tag, input logic rep, input int n,
                          input logic [11:0] exp_code, input int exp_lat,
                          input logic hold_start, input logic flip_repeat);
    int cycles;
    allow_repeat = rep;
    start = 1'b1;
    tick();
    if (!hold_start) start = 1'b0;
    if (flip_repeat) allow_repeat = ~rep;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_cleared"}, 32'(code_out), 32'd0);
    cycles = 0;
    while (!done && cycles < 64) begin
      rand_in = (cycles < n) ? stim[cycles] : 10'h3FF;
      tick();
      cycles++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(cycles + 1), 32'(exp_lat));
    check({tag, "_code"}, 32'(code_out), 32'(exp_code));
    check({tag, "_valid"}, 32'(code_valid), 32'd1);
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
    start = 1'b0;
    allow_repeat = rep;
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold_code"}, 32'(code_out), 32'(exp_code));
    check({tag, "_hold_valid"}, 32'(code_valid), 32'd1);
    tick();
    check({tag, "_idle"}, 32'(busy), 32'd0);
    $display("txn %s: code=0x%03h latency=%0d", tag, code_out, cycles + 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    allow_repeat = 1'b1;
    rand_in = 10'h000;
    tick();
    tick();
    check("rst_code", 32'(code_out), 32'd0);
    check("rst_valid", 32'(code_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    start = 1'b0;
    reset = 1'b0;
    tick();
    check("rst_stays_idle", 32'(busy), 32'd0);
    $display("txn reset: outputs cleared");

    // Pegs 1,2,3,4 with upper LFSR bits set to show they are ignored.
    stim[0] = 10'h001; stim[1] = 10'h3FA; stim[2] = 10'h0C3; stim[3] = 10'h204;
    run_code("normal", 1'b1, 4, 12'h8D1, 5, 1'b0, 1'b0);

    // 7,6 out of range; pegs 2,0,5,1.
    stim[0] = 10'h007; stim[1] = 10'h006; stim[2] = 10'h2C2; stim[3] = 10'h000;
    stim[4] = 10'h005; stim[5] = 10'h001;
    run_code("reject", 1'b1, 6, 12'h342, 7, 1'b0, 1'b0);

    // Second 3 is a duplicate; pegs 3,5,0,1.
    stim[0] = 10'h003; stim[1] = 10'h003; stim[2] = 10'h005; stim[3] = 10'h000;
    stim[4] = 10'h001;
    run_code("norepeat", 1'b0, 5, 12'h22B, 6, 1'b0, 1'b0);

    // Every word out of range: fallback picks 0,1,2,3 after 7 rejects each.
    run_code("fallback", 1'b0, 0, 12'h688, 33, 1'b0, 1'b0);

    // Repeats allowed: fallback is always 0.
    run_code("fallback_rep", 1'b1, 0, 12'h000, 33, 1'b0, 1'b0);

    // start held high the whole time; allow_repeat flipped after latch. Pegs 2,4,1,0.
    stim[0] = 10'h002; stim[1] = 10'h002; stim[2] = 10'h004; stim[3] = 10'h001;
    stim[4] = 10'h000;
    run_code("held_start", 1'b0, 5, 12'h062, 6, 1'b1, 1'b1);

    // Reset mid-collect, then a clean code.
    allow_repeat = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    rand_in = 10'h005;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_code", 32'(code_out), 32'd0);
    check("midrst_valid", 32'(code_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    $display("txn midreset: outputs cleared");
    tick();
    check("midrst_idle", 32'(busy), 32'd0);
    stim[0] = 10'h001; stim[1] = 10'h002; stim[2] = 10'h003; stim[3] = 10'h004;
    run_code("after_rst", 1'b1, 4, 12'h8D1, 5, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
